// File: rtl/serial_frame_decoder_pkg.sv
// Shared definitions for the serial frame encoder/decoder pair:
// receiver state encoding, default word width and the parity helper.
package serial_frame_decoder_pkg;

  localparam int unsigned DEFAULT_DATA_W = 3;
  localparam int unsigned MAX_DATA_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  // Parity bit that makes the frame correct: XOR of the word, inverted for odd parity.
  // Words narrower than MAX_DATA_W are passed zero-extended.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_frame_decoder.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), parity bit
// and stop bit, each sampled on a bit_en strobe. Good frames update data_out
// with a one-cycle valid_out pulse; bad parity or a low stop bit pulse an error.
module serial_frame_decoder
  import serial_frame_decoder_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned           CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              parity_bad_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;

  // Frame FSM with shift register and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      parity_bad_q <= 1'b0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!rx_in) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (cnt_q == CNT_W'(i)) shift_q[i] <= rx_in;
            end
            if (cnt_q == LAST_BIT) begin
              state_q <= PARITY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          PARITY: begin
            parity_bad_q <= (rx_in != parity_bit(MAX_DATA_W'(shift_q), PARITY_ODD));
            state_q      <= STOP;
          end
          STOP: begin
            if (rx_in) begin
              if (!parity_bad_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                perr_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
          BREAK: begin
            if (rx_in) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output mapping; busy follows the state directly.
  always_comb begin
    data_out   = data_q;
    valid_out  = valid_q;
    parity_err = perr_q;
    frame_err  = ferr_q;
    busy       = (state_q != IDLE);
  end

endmodule
